xlce_sample_buffer: RTL and testbench

XLCE_SAMPLE_BUFFER -- requirements
Module: xlce_sample_buffer

---
 rtl/xlce_sample_buffer.sv | 104 ++++++++++
 tb/tb_xlce_sample_buffer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/xlce_sample_buffer.sv
// Rate-aligned sample FIFO: buffers upstream samples and emits one per ce pulse.
// Optional XLCE_UNDERFLOW_COUNT_EN adds a saturating 16-bit underflow counter.
module xlce_sample_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  sysclk,
  input  logic                  sysclr_n,
  input  logic                  sysce,
  input  logic                  ce,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underflow
`ifdef XLCE_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0]           underflow_cnt
`endif
);

  localparam logic [DEPTH_LOG2:0] LP_DEPTH =
    (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  logic [DATA_WIDTH-1:0] r_mem [LP_DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_dout_vld;
  logic                  r_underflow;

  logic w_ready;
  logic w_push;
  logic w_tick;
  logic w_pop;
  logic w_under;

  assign w_ready = (r_level < LP_DEPTH) & sysce & ~flush;
  assign w_push  = s_tvalid & w_ready;
  // rate tick only counts when enabled and not being flushed
  assign w_tick  = sysce & ce & ~flush;
  assign w_pop   = w_tick & (r_level != '0);
  assign w_under = w_tick & (r_level == '0);

  // storage is not reset; occupancy is tracked by the pointers/level
  always_ff @(posedge sysclk) begin
    if (w_push) r_mem[r_wptr] <= s_tdata;
  end

  always_ff @(posedge sysclk or negedge sysclr_n) begin
    if (!sysclr_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_dout      <= '0;
      r_dout_vld  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!sysce) begin
      r_dout_vld  <= 1'b0;
    end else if (flush) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_dout_vld  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_dout_vld <= w_pop;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_dout <= r_mem[r_rptr];
      end
      if (w_push && !w_pop) r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
      if (w_under) r_underflow <= 1'b1;
    end
  end

`ifdef XLCE_UNDERFLOW_COUNT_EN
  logic [15:0] r_ucnt;

  always_ff @(posedge sysclk or negedge sysclr_n) begin
    if (!sysclr_n) begin
      r_ucnt <= '0;
    end else if (sysce) begin
      if (flush) r_ucnt <= '0;
      else if (w_under && r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 1'b1;
    end
  end

  assign underflow_cnt = r_ucnt;
`endif

  assign s_tready  = w_ready;
  assign dout      = r_dout;
  assign dout_vld  = r_dout_vld;
  assign level     = r_level;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_xlce_sample_buffer.sv
// Directed self-checking bench for xlce_sample_buffer.
// Define XLCE_UNDERFLOW_COUNT_EN to also check underflow_cnt.
module tb_xlce_sample_buffer;

  logic        sysclk = 1'b0;
  logic        sysclr_n;
  logic        sysce;
  logic        ce;
  logic        flush;
  logic [15:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] dout;
  logic        dout_vld;
  logic [3:0]  level;
  logic        underflow;
`ifdef XLCE_UNDERFLOW_COUNT_EN
  logic [15:0] underflow_cnt;
`endif

  int ncmp = 0;
  int nerr = 0;

  xlce_sample_buffer #(.DATA_WIDTH(16), .DEPTH_LOG2(3)) dut (
    .sysclk   (sysclk),
    .sysclr_n (sysclr_n),
    .sysce    (sysce),
    .ce       (ce),
    .flush    (flush),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .dout     (dout),
    .dout_vld (dout_vld),
    .level    (level),
    .underflow(underflow)
`ifdef XLCE_UNDERFLOW_COUNT_EN
    ,
    .underflow_cnt(underflow_cnt)
`endif
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk_ucnt(input string tag, input logic [15:0] exp);
`ifdef XLCE_UNDERFLOW_COUNT_EN
    chk(tag, 32'(underflow_cnt), 32'(exp));
`else
    if (exp === 16'hxxxx) $display("unused %s", tag);
`endif
  endtask

  logic [15:0] exp_q [3];

  initial begin
    exp_q[0] = 16'h0011;
    exp_q[1] = 16'h0022;
    exp_q[2] = 16'h0033;
    sysclr_n = 1'b0;
    sysce    = 1'b1;
    ce       = 1'b0;
    flush    = 1'b0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    #3;
    chk("rst_level", 32'(level), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_vld", 32'(dout_vld), 0);
    chk("rst_uflow", 32'(underflow), 0);
    chk_ucnt("rst_ucnt", 16'd0);
    tick();
    tick();
    sysclr_n = 1'b1;

    // three back-to-back pushes, then ce every 4 cycles
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = exp_q[i];
      tick();
      chk("push_level", 32'(level), 32'(i + 1));
    end
    s_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ce = 1'b1;
      tick();
      ce = 1'b0;
      chk("pop_dout", 32'(dout), 32'(exp_q[i]));
      chk("pop_vld", 32'(dout_vld), 1);
      chk("pop_level", 32'(level), 32'(2 - i));
      tick();
      chk("pop_vld_low", 32'(dout_vld), 0);
      chk("pop_hold", 32'(dout), 32'(exp_q[i]));
      tick();
      tick();
    end

    // empty-FIFO ce pulses
    ce = 1'b1;
    tick();
    chk("uf_vld", 32'(dout_vld), 0);
    chk("uf_dout", 32'(dout), 32'h33);
    chk("uf_flag", 32'(underflow), 1);
    chk_ucnt("uf_cnt1", 16'd1);
    tick();
    ce = 1'b0;
    chk("uf_level", 32'(level), 0);
    chk_ucnt("uf_cnt2", 16'd2);

    // level 5 with underflow set, then flush with ce
    for (int i = 0; i < 5; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 16'(16'h0101 + i);
      tick();
    end
    s_tvalid = 1'b0;
    chk("fl_pre_level", 32'(level), 5);
    chk("fl_pre_uflow", 32'(underflow), 1);
    flush = 1'b1;
    ce    = 1'b1;
    #1;
    chk("fl_ready", 32'(s_tready), 0);
    tick();
    flush = 1'b0;
    ce    = 1'b0;
    chk("fl_level", 32'(level), 0);
    chk("fl_uflow", 32'(underflow), 0);
    chk("fl_dout", 32'(dout), 32'h33);
    chk("fl_vld", 32'(dout_vld), 0);
    chk_ucnt("fl_ucnt", 16'd0);

    // fill to 8 with s_tvalid held high
    s_tvalid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_tdata = 16'(16'h0200 + i);
      tick();
    end
    chk("full_level", 32'(level), 8);
    chk("full_ready", 32'(s_tready), 0);
    s_tdata = 16'h02FF;
    tick();
    chk("full_hold", 32'(level), 8);
    ce = 1'b1;
    tick();
    chk("full_pop_dout", 32'(dout), 32'h0200);
    chk("full_pop_level", 32'(level), 7);
    chk("full_ready_back", 32'(s_tready), 1);
    s_tvalid = 1'b0;

    // drain to level 4, then simultaneous push and pop
    tick();
    tick();
    tick();
    chk("pp_pre_level", 32'(level), 4);
    chk("pp_pre_dout", 32'(dout), 32'h0203);
    s_tvalid = 1'b1;
    s_tdata  = 16'h0300;
    tick();
    ce       = 1'b0;
    s_tvalid = 1'b0;
    chk("pp_level", 32'(level), 4);
    chk("pp_dout", 32'(dout), 32'h0204);

    // pop, then sysce low for 3 cycles with toggling ce/s_tvalid
    ce = 1'b1;
    tick();
    chk("ce_dout", 32'(dout), 32'h0205);
    chk("ce_vld", 32'(dout_vld), 1);
    sysce = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ce       = (i % 2) == 0;
      s_tvalid = (i % 2) != 0;
      s_tdata  = 16'h0BAD;
      #1;
      chk("sce_ready", 32'(s_tready), 0);
      tick();
      chk("sce_level", 32'(level), 3);
      chk("sce_dout", 32'(dout), 32'h0205);
      chk("sce_vld", 32'(dout_vld), 0);
    end
    sysce    = 1'b1;
    s_tvalid = 1'b0;
    ce       = 1'b1;
    tick();
    ce = 1'b0;
    chk("sce_next_dout", 32'(dout), 32'h0206);
    chk("sce_next_level", 32'(level), 2);

    // asynchronous reset mid-stream
    s_tvalid = 1'b1;
    s_tdata  = 16'h0400;
    #2;
    sysclr_n = 1'b0;
    #1;
    chk("arst_level", 32'(level), 0);
    chk("arst_dout", 32'(dout), 0);
    chk("arst_vld", 32'(dout_vld), 0);
    chk("arst_uflow", 32'(underflow), 0);
    s_tvalid = 1'b0;
    tick();
    #2;
    sysclr_n = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 16'h0500;
    tick();
    s_tvalid = 1'b0;
    chk("post_rst_level", 32'(level), 1);
    ce = 1'b1;
    tick();
    chk("post_rst_dout", 32'(dout), 32'h0500);
    chk("post_rst_empty", 32'(level), 0);
    tick();
    ce = 1'b0;
    chk("post_rst_uflow", 32'(underflow), 1);
    chk("post_rst_vld", 32'(dout_vld), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
